// File: rtl/float_normalize.sv
// Normalizes a raw add/sub result (sticky right shift or SHIFT_STEP-bit left shifts), then rounds and packs it into IEEE-754 single precision.
// Latency: out_valid 3 cycles after accept (+1 per NORM cycle), one cycle less when FLOAT_NORMALIZE_ROUND_EN is not defined (truncate).
// Backpressure: in_ready only in IDLE; result and flags hold in DONE until out_ready; rst is synchronous, active-low.
module float_normalize #(
    parameter int SHIFT_STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exponent,
    input  logic [26:0] in_mantissa,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        out_overflow,
    output logic        out_underflow,
    output logic        out_zero
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_NORM  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd4;
`ifdef FLOAT_NORMALIZE_ROUND_EN
    localparam logic [2:0] S_ROUND = 3'd3;
    localparam logic [2:0] S_POST  = S_ROUND;
`else
    localparam logic [2:0] S_POST  = S_DONE;
`endif

    localparam logic [8:0] STEP_EXP = 9'(SHIFT_STEP);

    logic [2:0]  state_q, state_d;
    logic        sign_q, sign_d;
    // Nine bits so a rounding or carry increment past 0xFE is still visible as overflow.
    logic [8:0]  exp_q, exp_d;
    logic [26:0] mant_q, mant_d;
    logic        zero_q, zero_d;
    logic        unf_q, unf_d;

    logic [26:0] mant_shift;
    logic [8:0]  exp_shift;
    logic        big_ok;
    logic        ovf;

`ifdef FLOAT_NORMALIZE_ROUND_EN
    logic        rnd_inc;
    logic [23:0] frac_inc;
`endif

    // Left-shift candidate for one NORM cycle; big steps only when they cannot overshoot the hidden bit or drive the exponent below 1.
    always_comb begin
        big_ok = (mant_q[25 -: SHIFT_STEP] == '0) && (exp_q > STEP_EXP);
        if (big_ok) begin
            mant_shift = mant_q << SHIFT_STEP;
            exp_shift  = exp_q - STEP_EXP;
        end else begin
            mant_shift = mant_q << 1;
            exp_shift  = exp_q - 9'd1;
        end
    end

`ifdef FLOAT_NORMALIZE_ROUND_EN
    // Round-to-nearest-even on the 23-bit fraction; bit 23 of frac_inc is the carry-out.
    always_comb begin
        rnd_inc  = mant_q[1] && (mant_q[0] || mant_q[2]);
        frac_inc = {1'b0, mant_q[24:2]} + 24'(rnd_inc);
    end
`endif

    // Control FSM and datapath next-state.
    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        mant_d  = mant_q;
        zero_d  = zero_q;
        unf_d   = unf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sign_d  = in_sign;
                    exp_d   = {1'b0, in_exponent};
                    mant_d  = in_mantissa;
                    zero_d  = 1'b0;
                    unf_d   = 1'b0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (mant_q == '0) begin
                    sign_d  = 1'b0;
                    exp_d   = '0;
                    zero_d  = 1'b1;
                    state_d = S_DONE;
                end else if (exp_q == 9'h0FF) begin
                    state_d = S_DONE;
                end else if (mant_q[26]) begin
                    // Bit shifted out of the guard position folds into sticky.
                    mant_d  = {1'b0, mant_q[26:2], mant_q[1] | mant_q[0]};
                    exp_d   = exp_q + 9'd1;
                    state_d = S_POST;
                end else if (mant_q[25]) begin
                    state_d = S_POST;
                end else begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                // The flush test looks at the register value at the start of the cycle; no denormals are produced.
                if ((exp_q <= 9'd1) && !mant_q[25]) begin
                    exp_d   = '0;
                    mant_d  = '0;
                    zero_d  = 1'b1;
                    unf_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    mant_d = mant_shift;
                    exp_d  = exp_shift;
                    if (mant_shift[25]) begin
                        state_d = S_POST;
                    end
                end
            end
`ifdef FLOAT_NORMALIZE_ROUND_EN
            S_ROUND: begin
                if (frac_inc[23]) begin
                    mant_d = {2'b01, 23'd0, 2'b00};
                    exp_d  = exp_q + 9'd1;
                end else begin
                    mant_d = {mant_q[26:25], frac_inc[22:0], 2'b00};
                end
                state_d = S_DONE;
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            mant_q  <= '0;
            zero_q  <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            mant_q  <= mant_d;
            zero_q  <= zero_d;
            unf_q   <= unf_d;
        end
    end

    // Outputs decode from held state; gating with rst keeps them at zero while reset is asserted.
    always_comb begin
        in_ready      = rst && (state_q == S_IDLE);
        out_valid     = rst && (state_q == S_DONE);
        ovf           = (exp_q >= 9'h0FF);
        result        = '0;
        out_overflow  = 1'b0;
        out_underflow = 1'b0;
        out_zero      = 1'b0;
        if (out_valid) begin
            result        = ovf ? {sign_q, 8'hFF, 23'd0} : {sign_q, exp_q[7:0], mant_q[24:2]};
            out_overflow  = ovf;
            out_underflow = unf_q;
            out_zero      = zero_q;
        end
    end

endmodule

// File: doc/float_normalize.md
FLOAT_NORMALIZE -- requirements
Module: float_normalize

Interface
REQ-001 SHALL have parameter SHIFT_STEP, default 1, giving the maximum left-shift distance per NORM cycle; legal values are 1, 2 and 4.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1, reset: synchronous and active-low, sampled on the clk rising edge.
REQ-004 SHALL have port in_valid, input, 1, upstream add/sub result is present.
REQ-005 SHALL have port in_ready, output, 1, block can accept an input this cycle.
REQ-006 SHALL have port in_sign, input, 1, sign of the raw result.
REQ-007 SHALL have port in_exponent, input, 8, biased exponent of the raw result.
REQ-008 SHALL have port in_mantissa, input, 27, the raw mantissa: [26] carry, [25] hidden, [24:2] fraction, [1] guard, [0] sticky.
REQ-009 SHALL have port out_valid, output, 1, result and flags are valid.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-011 SHALL have port result, output, 32, IEEE-754 single-precision word.
REQ-012 SHALL have ports out_overflow, out_underflow and out_zero, each output, 1, status flags qualified by out_valid.

Function
REQ-013 SHALL implement the states IDLE, CHECK, NORM, ROUND and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE.
REQ-015 SHALL register sign, exponent and mantissa when in_valid&&in_ready, and SHALL then enter CHECK.
REQ-016 CHECK, mantissa zero: SHALL go to DONE with result 0x00000000 and out_zero=1.
REQ-017 CHECK, input exponent 0xFF: SHALL go to DONE with result {sign,0xFF,0} and out_overflow=1.
REQ-018 CHECK, carry set: SHALL shift the mantissa right 1, OR the shifted-out bit into sticky, add 1 to the exponent, and go to ROUND.
REQ-019 CHECK, hidden set: SHALL go to ROUND. Otherwise CHECK SHALL go to NORM.
REQ-020 NORM: each cycle SHALL shift left by SHIFT_STEP if mantissa[25:26-SHIFT_STEP] are all zero and exponent > SHIFT_STEP; otherwise it SHALL shift left by 1. The exponent SHALL decrease by the same amount, and zero SHALL fill from the LSB.
REQ-021 NORM: SHALL go to ROUND when hidden=1 after the shift.
REQ-022 NORM: if the exponent is 1 and hidden is 0, SHALL flush (no denormals) to DONE with result {sign,0,0}, out_underflow=1 and out_zero=1.
REQ-023 ROUND: SHALL apply round-to-nearest-even, incrementing the fraction iff guard && (sticky || fraction[0]).
REQ-024 ROUND: a fraction carry-out SHALL clear the fraction and add 1 to the exponent.
REQ-025 ROUND: SHALL go to DONE.
REQ-026 DONE: if the exponent is ≥ 0xFF, result SHALL be {sign,0xFF,0} with out_overflow=1; otherwise result SHALL be {sign,exponent,fraction}.
REQ-027 DONE: out_valid SHALL be 1, and result and flags SHALL be held stable until out_ready=1, then the block SHALL enter IDLE.
REQ-028 Latency: with accept at cycle N, out_valid SHALL rise at N+3 for normalized or carry input, and at N+3+k for k NORM cycles.
REQ-029 out_ready SHALL be ignored outside DONE, and in_valid SHALL be ignored outside IDLE.
REQ-030 The exponent SHALL be held internally as 9 bits so that increment wrap is detected.

Reset
REQ-031 rst=0 at any clock edge SHALL force IDLE and SHALL abort any in-flight operation, including one in NORM or DONE.
REQ-032 During reset, in_ready SHALL be 0 and out_valid, result, out_overflow, out_underflow and out_zero SHALL all be 0.
REQ-033 in_ready SHALL be 1 in the first cycle after rst returns to 1.

Configuration
REQ-034 With macro FLOAT_NORMALIZE_ROUND_EN defined, ROUND SHALL behave per REQ-023..025.
REQ-035 Without FLOAT_NORMALIZE_ROUND_EN, ROUND SHALL be omitted: guard and sticky SHALL be discarded (truncate), CHECK and NORM SHALL go straight to DONE, and every REQ-028 latency SHALL be one cycle shorter.

Verification
REQ-036 Normalized input: exp 0x7F, mantissa 27'h2000000, out_ready=1 -> result 0x3F800000, flags 0, out_valid at N+3.
REQ-037 Carry input: exp 0x7F, mantissa 27'h4000000 -> result 0x40000000.
REQ-038 Left shift, SHIFT_STEP=1: exp 0x80, mantissa 27'h0400000 -> result 0x3E800000, out_valid at N+6.
REQ-039 Tie to even: exp 0x7F, mantissa 27'h2000006 -> result 0x3F800002 with the macro, 0x3F800001 without it.
REQ-040 Overflow: exp 0xFE, mantissa 27'h4000000 -> result 0x7F800000, out_overflow=1.
REQ-041 Backpressure then reset: out_ready=0 for 5 cycles -> result held constant; then rst=0 during a NORM cycle of a new op -> all outputs 0, and in_ready=1 one cycle after rst=1.
